// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction memory and its loader:
// NOP opcode, loader state encoding and {instr, arg} word-pack helpers.
package cpu_pkg;

  localparam int NOP_OPCODE = 0;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  // A packed word is {instr, arg}; these give the MSB of each field.
  function automatic int instr_msb(input int width);
    return 2 * width - 1;
  endfunction

  function automatic int arg_msb(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Load-port sequencer: valid/ready handshake, write pointer and word count,
// driving the write port of the instruction array.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal fetch operation, loader not accepting words
//   LOAD  | accepting one word per valid beat until last beat or full
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int CW    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [2*WIDTH-1:0] load_data,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic [CW-1:0]      load_count,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [2*WIDTH-1:0] wdata
);

  load_state_e   state, state_nxt;
  logic [CW-1:0] count;
  logic          accept;
  logic          final_beat;

  assign accept     = (state == LOAD) && load_valid;
  assign final_beat = accept && (load_last || (count == CW'(DEPTH - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (load_start) state_nxt = LOAD;
      LOAD:    if (final_beat) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    load_ready = (state == LOAD);
    load_busy  = (state == LOAD);
    we         = accept;
  end

  // count doubles as the write pointer; it is left at its final value on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= final_beat;
      if ((state == RUN) && load_start) count <= '0;
      else if (accept)                  count <= count + 1'b1;
    end
  end

  assign load_count = count;
  assign waddr      = count[AW-1:0];
  assign wdata      = load_data;

endmodule

// File: rtl/instr_mem.sv
// Clocked program memory: registered {instr, arg} fetch port with 1-cycle
// latency, plus an in-system load port for rewriting contents at run time.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 32,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           instr,
  output logic [WIDTH-1:0]           arg,
  output logic                       instr_valid,
  output logic                       addr_err,
  input  logic                       load_start,
  input  logic [2*WIDTH-1:0]         load_data,
  input  logic                       load_valid,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       load_busy,
  output logic                       load_done,
  output logic [$clog2(DEPTH+1)-1:0] load_count
);

  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int INSTR_MSB = instr_msb(WIDTH);
  localparam int ARG_MSB   = arg_msb(WIDTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic               we;
  logic [AW-1:0]      waddr;
  logic [2*WIDTH-1:0] wdata;
  logic               fetch;
  logic               in_range;
  logic [2*WIDTH-1:0] rword;

  // Elaboration-time contents; the array itself is never reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  instr_mem_loader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_count (load_count),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // load_start wins over a same-cycle fetch; fetches are ignored during LOAD.
  assign fetch    = rd_en && !load_busy && !load_start;
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign rword    = mem[addr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      arg         <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      instr_valid <= fetch;
      addr_err    <= fetch && !in_range;
      if (fetch) begin
        if (in_range) begin
          instr <= rword[INSTR_MSB:WIDTH];
          arg   <= rword[ARG_MSB:0];
        end else begin
          instr <= WIDTH'(NOP_OPCODE);
          arg   <= '0;
        end
      end
    end
  end

endmodule
